// File: rtl/clint_pkg.sv
// ============================================================================
// Module      : clint_pkg
// Description : Shared definitions for the core-local interruptor. Holds the
//               register offsets, the request FSM state type and the reset
//               value of the timer compare register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clint_pkg;

  // Byte offsets of the memory-mapped registers (bits [1:0] never decoded)
  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  // Compare register starts at all-ones so the timer interrupt stays quiet
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [0:0] {
    CLINT_IDLE = 1'b0,
    CLINT_RESP = 1'b1
  } clint_state_e;

endpackage : clint_pkg

`default_nettype wire

// File: rtl/clint_prescaler.sv
// ============================================================================
// Module      : clint_prescaler
// Description : Tick generator for mtime. A 16-bit counter runs
//               0..TICK_DIV-1 and emits a one-cycle tick on the wrap.
//               Only instantiated when CLINT_PRESCALE_EN is defined.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               clr_i   - restart the count at 0 (mtime was written)
//               tick_o  - mtime increment enable
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [15:0] C_LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick_o = (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr_i || tick_o) begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : clint_prescaler

`default_nettype wire

// File: rtl/int_clint.sv
// ============================================================================
// Module      : int_clint
// Description : Core-local interruptor. Free-running 64-bit mtime, 64-bit
//               mtimecmp and the msip bit behind a single-outstanding
//               valid/ready request/response port. Produces registered
//               timer and software interrupt levels.
// Config      : CLINT_PRESCALE_EN - when defined, mtime advances once per
//               TICK_DIV clocks through clint_prescaler; otherwise every clock.
// Ports       : lsu_clint_vld/clint_lsu_rdy      - request handshake
//               lsu_clint_wr/addr/wdata           - request payload
//               clint_lsu_rsp_vld/lsu_clint_rsp_rdy - response handshake
//               clint_lsu_rdata/clint_lsu_err     - response payload
//               clint_int_tmr/clint_int_sft       - interrupt levels
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned CSR_DW   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_clint_vld,
  output logic        clint_lsu_rdy,
  input  logic        lsu_clint_wr,
  input  logic [15:0] lsu_clint_addr,
  input  logic [31:0] lsu_clint_wdata,
  output logic        clint_lsu_rsp_vld,
  input  logic        lsu_clint_rsp_rdy,
  output logic [31:0] clint_lsu_rdata,
  output logic        clint_lsu_err,
  output logic        clint_int_tmr,
  output logic        clint_int_sft
);

  clint_state_e      state_q, state_d;
  logic [CSR_DW-1:0] mtime_q, mtime_d;
  logic [CSR_DW-1:0] mtimecmp_q, mtimecmp_d;
  logic              msip_q, msip_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tmr_q, sft_q;

  logic        w_accept, w_we, w_tick, w_mapped;
  logic        w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi, w_sel_mt_lo, w_sel_mt_hi;
  logic [31:0] w_rd;
  logic [13:0] w_word;
  logic [1:0]  w_unused_addr;

  assign w_word        = lsu_clint_addr[15:2];
  assign w_unused_addr = lsu_clint_addr[1:0];

  assign w_sel_msip   = (w_word == CLINT_MSIP[15:2]);
  assign w_sel_cmp_lo = (w_word == CLINT_MTIMECMP_LO[15:2]);
  assign w_sel_cmp_hi = (w_word == CLINT_MTIMECMP_HI[15:2]);
  assign w_sel_mt_lo  = (w_word == CLINT_MTIME_LO[15:2]);
  assign w_sel_mt_hi  = (w_word == CLINT_MTIME_HI[15:2]);
  assign w_mapped     = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi
                      | w_sel_mt_lo | w_sel_mt_hi;

  assign w_accept = (state_q == CLINT_IDLE) && lsu_clint_vld;
  assign w_we     = w_accept && lsu_clint_wr;

`ifdef CLINT_PRESCALE_EN
  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_we && (w_sel_mt_lo || w_sel_mt_hi)),
    .tick_o (w_tick)
  );
`else
  // TICK_DIV has no effect without the prescaler: tick every clock.
  if (TICK_DIV >= 1) begin : g_tick_every_clk
    assign w_tick = 1'b1;
  end else begin : g_tick_every_clk_div0
    assign w_tick = 1'b1;
  end
`endif

  // Read mux sees pre-increment register values
  always_comb begin
    w_rd = 32'd0;
    if (w_sel_msip)   w_rd = {31'd0, msip_q};
    if (w_sel_cmp_lo) w_rd = mtimecmp_q[31:0];
    if (w_sel_cmp_hi) w_rd = mtimecmp_q[CSR_DW-1:32];
    if (w_sel_mt_lo)  w_rd = mtime_q[31:0];
    if (w_sel_mt_hi)  w_rd = mtime_q[CSR_DW-1:32];
  end

  // A half-write overrides the tick entirely for that cycle, so no carry
  // leaks from the running count into the untouched half.
  always_comb begin
    mtime_d    = mtime_q + CSR_DW'(w_tick);
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (w_we) begin
      if (w_sel_mt_lo)  mtime_d    = {mtime_q[CSR_DW-1:32], lsu_clint_wdata};
      if (w_sel_mt_hi)  mtime_d    = {lsu_clint_wdata, mtime_q[31:0]};
      if (w_sel_cmp_lo) mtimecmp_d = {mtimecmp_q[CSR_DW-1:32], lsu_clint_wdata};
      if (w_sel_cmp_hi) mtimecmp_d = {lsu_clint_wdata, mtimecmp_q[31:0]};
      if (w_sel_msip)   msip_d     = lsu_clint_wdata[0];
    end
  end

  // Response register only loads on acceptance, holding it stable in RESP
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (w_accept) begin
      rdata_d = lsu_clint_wr ? 32'd0 : w_rd;
      err_d   = ~w_mapped;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLINT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLINT_IDLE: if (lsu_clint_vld)     state_d = CLINT_RESP;
      CLINT_RESP: if (lsu_clint_rsp_rdy) state_d = CLINT_IDLE;
      default:                           state_d = CLINT_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    clint_lsu_rdy     = 1'b0;
    clint_lsu_rsp_vld = 1'b0;
    case (state_q)
      CLINT_IDLE: clint_lsu_rdy     = 1'b1;
      CLINT_RESP: clint_lsu_rsp_vld = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= CLINT_MTIMECMP_RST;
      msip_q     <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      tmr_q      <= 1'b0;
      sft_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmr_q      <= (mtime_q >= mtimecmp_q);
      sft_q      <= msip_q;
    end
  end

  assign clint_lsu_rdata = rdata_q;
  assign clint_lsu_err   = err_q;
  assign clint_int_tmr   = tmr_q;
  assign clint_int_sft   = sft_q;

endmodule : int_clint

`default_nettype wire

// File: tb/tb_int_clint.sv
// ============================================================================
// Module      : tb_int_clint
// Description : Self-checking bench for int_clint. A cycle-level behavioural
//               model of the register map is stepped alongside the DUT and
//               every DUT output is compared each cycle; directed steps cover
//               reset, msip, timer compare, wrap, errors and back-pressure,
//               followed by random transactions.
// Config      : CLINT_PRESCALE_EN - selects the prescaled model and test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_clint;

  localparam int unsigned TDIV = 4;

  logic        clk;
  logic        rst;
  logic        vld;
  logic        rdy;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rdata;
  logic        err;
  logic        int_tmr;
  logic        int_sft;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_tmr, m_sft, m_busy, m_rerr;
  logic [31:0] m_rdata;
  int unsigned m_pre;

  int_clint #(
    .TICK_DIV (TDIV),
    .CSR_DW   (64)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .lsu_clint_vld     (vld),
    .clint_lsu_rdy     (rdy),
    .lsu_clint_wr      (wr),
    .lsu_clint_addr    (addr),
    .lsu_clint_wdata   (wdata),
    .clint_lsu_rsp_vld (rsp_vld),
    .lsu_clint_rsp_rdy (rsp_rdy),
    .clint_lsu_rdata   (rdata),
    .clint_lsu_err     (err),
    .clint_int_tmr     (int_tmr),
    .clint_int_sft     (int_sft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-map read as seen by software: {err, data}
  function automatic logic [32:0] model_read(input logic [15:0] a);
    case (a & 16'hFFFC)
      16'h0000: model_read = {1'b0, 31'd0, m_msip};
      16'h4000: model_read = {1'b0, m_cmp[31:0]};
      16'h4004: model_read = {1'b0, m_cmp[63:32]};
      16'hBFF8: model_read = {1'b0, m_mtime[31:0]};
      16'hBFFC: model_read = {1'b0, m_mtime[63:32]};
      default:  model_read = {1'b1, 32'd0};
    endcase
  endfunction

  // Advance model and DUT by one clock, then compare all outputs
  task automatic step();
    logic [63:0] n_mtime, n_cmp;
    logic        n_msip, n_tmr, n_sft, n_busy, n_rerr, acc, tick;
    logic [31:0] n_rdata;
    logic [32:0] rd;
    int unsigned n_pre;
    if (rst) begin
      n_mtime = 64'd0; n_cmp = 64'hFFFF_FFFF_FFFF_FFFF; n_msip = 1'b0;
      n_tmr = 1'b0; n_sft = 1'b0; n_busy = 1'b0; n_rerr = 1'b0;
      n_rdata = 32'd0; n_pre = 0;
    end else begin
      acc = !m_busy && vld;
`ifdef CLINT_PRESCALE_EN
      tick = (m_pre == TDIV - 1);
`else
      tick = 1'b1;
`endif
      n_pre   = tick ? 0 : m_pre + 1;
      n_mtime = m_mtime + 64'(tick);
      n_cmp   = m_cmp;
      n_msip  = m_msip;
      n_tmr   = (m_mtime >= m_cmp);
      n_sft   = m_msip;
      n_busy  = m_busy;
      n_rdata = m_rdata;
      n_rerr  = m_rerr;
      if (acc) begin
        rd = model_read(addr);
        if (wr) begin
          case (addr & 16'hFFFC)
            16'h0000: n_msip = wdata[0];
            16'h4000: n_cmp = {m_cmp[63:32], wdata};
            16'h4004: n_cmp = {wdata, m_cmp[31:0]};
            16'hBFF8: begin n_mtime = {m_mtime[63:32], wdata}; n_pre = 0; end
            16'hBFFC: begin n_mtime = {wdata, m_mtime[31:0]}; n_pre = 0; end
            default: ;
          endcase
        end
        n_rdata = wr ? 32'd0 : rd[31:0];
        n_rerr  = rd[32];
        n_busy  = 1'b1;
      end else if (m_busy && rsp_rdy) begin
        n_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_mtime = n_mtime; m_cmp = n_cmp; m_msip = n_msip; m_tmr = n_tmr;
    m_sft = n_sft; m_busy = n_busy; m_rdata = n_rdata; m_rerr = n_rerr;
    m_pre = n_pre;
    chk("rdy", 64'(rdy), 64'(!m_busy));
    chk("rsp_vld", 64'(rsp_vld), 64'(m_busy));
    chk("int_tmr", 64'(int_tmr), 64'(m_tmr));
    chk("int_sft", 64'(int_sft), 64'(m_sft));
    if (m_busy) begin
      chk("rdata", 64'(rdata), 64'(m_rdata));
      chk("err", 64'(err), 64'(m_rerr));
    end
  endtask

  // One request; response held off for 'hold' cycles, optionally with a
  // competing request kept valid throughout the response phase.
  task automatic xact(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input int hold, input logic keep_vld,
                      output logic [31:0] r, output logic e);
    vld = 1'b1; wr = w; addr = a; wdata = d; rsp_rdy = 1'b0;
    step();
    r = rdata; e = err;
    if (!keep_vld) vld = 1'b0;
    for (int i = 0; i < hold; i++) step();
    rsp_rdy = 1'b1;
    step();
    vld = 1'b0; rsp_rdy = 1'b0;
  endtask

  logic [31:0] r;
  logic        e;
  logic [15:0] amap [5] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};

  initial begin
    rst = 1'b1; vld = 1'b0; wr = 1'b0; addr = 16'd0; wdata = 32'd0; rsp_rdy = 1'b0;
    m_pre = 0; m_busy = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_rdy", 64'(rdy), 64'd1);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_tmr", 64'(int_tmr), 64'd0);
    chk("rst_sft", 64'(int_sft), 64'd0);

`ifdef CLINT_PRESCALE_EN
    for (int i = 0; i < 100; i++) step();
    xact(1'b0, 16'hBFF8, 32'd0, 0, 1'b0, r, e);
    chk("presc_mtime_25", 64'(r), 64'd25);
`endif

    xact(1'b0, 16'h4000, 32'd0, 0, 1'b0, r, e);
    chk("cmp_lo_rst", 64'(r), 64'hFFFF_FFFF);
    xact(1'b0, 16'h4004, 32'd0, 0, 1'b0, r, e);
    chk("cmp_hi_rst", 64'(r), 64'hFFFF_FFFF);

    // Software interrupt
    xact(1'b1, 16'h0000, 32'd1, 0, 1'b0, r, e);
    chk("sft_set", 64'(int_sft), 64'd1);
    xact(1'b1, 16'h0000, 32'hFFFF_FFFE, 0, 1'b0, r, e);
    chk("sft_clr", 64'(int_sft), 64'd0);

    // Timer compare at 20 with mtime restarted near 0
    xact(1'b1, 16'hBFF8, 32'd0, 0, 1'b0, r, e);
    xact(1'b1, 16'hBFFC, 32'd0, 0, 1'b0, r, e);
    xact(1'b1, 16'h4004, 32'd0, 0, 1'b0, r, e);
    xact(1'b1, 16'h4000, 32'd20, 0, 1'b0, r, e);
    chk("tmr_before", 64'(int_tmr), 64'd0);
    for (int i = 0; i < 100; i++) step();
    chk("tmr_reached", 64'(int_tmr), 64'd1);
    xact(1'b1, 16'h4000, 32'hFFFF_FFFF, 0, 1'b0, r, e);
    step();
    chk("tmr_deassert", 64'(int_tmr), 64'd0);

`ifndef CLINT_PRESCALE_EN
    // Wrap: mtime = all ones then 0; tmr with cmp=5 falls after the wrap
    xact(1'b1, 16'h4000, 32'd5, 0, 1'b0, r, e);
    xact(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 0, 1'b0, r, e);
    xact(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 0, 1'b0, r, e);
    chk("wrap_tmr_hi", 64'(int_tmr), 64'd1);
    step();
    chk("wrap_tmr_lo", 64'(int_tmr), 64'd0);
    xact(1'b0, 16'hBFFC, 32'd0, 0, 1'b0, r, e);
    chk("wrap_mtime_hi", 64'(r), 64'd0);
`endif

    // Unmapped read with back-pressure and a competing request
    xact(1'b0, 16'h1234, 32'd0, 5, 1'b1, r, e);
    chk("unmapped_err", 64'(e), 64'd1);
    chk("unmapped_rdata", 64'(r), 64'd0);

    // Reset while a write response is pending drops the response
    vld = 1'b1; wr = 1'b1; addr = 16'h0000; wdata = 32'd1;
    step();
    vld = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_in_resp", 64'(rsp_vld), 64'd0);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom) : amap[$urandom_range(0, 4)];
      a[1:0] = 2'($urandom);
      xact(1'($urandom), a, $urandom, int'($urandom_range(0, 3)),
           1'($urandom), r, e);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_int_clint

`default_nettype wire

// File: doc/int_clint.md
# int_clint

Core-local interruptor feeding the interrupt controller's `tmr_irq` and `sft_irq` inputs. It holds a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and the `msip` software-interrupt bit. All three are memory-mapped behind a single-outstanding valid/ready request/response port driven by the LSU. Both interrupt outputs are registered levels that the interrupt controller consumes directly.

## Interface
- `TICK_DIV`, default 1: `mtime` increments once per `TICK_DIV` clocks. Legal range 1..65535. Used only with `CLINT_PRESCALE_EN`.
- `CSR_DW`, default 64: `mtime`/`mtimecmp` width. Fixed at 64.
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous, active-high.
- `lsu_clint_vld` input 1: request valid.
- `clint_lsu_rdy` output 1: request ready.
- `lsu_clint_wr` input 1: 1 = write, 0 = read.
- `lsu_clint_addr` input 16: byte offset, word aligned; bits [1:0] ignored.
- `lsu_clint_wdata` input 32: write data.
- `clint_lsu_rsp_vld` output 1: response valid.
- `lsu_clint_rsp_rdy` input 1: response ready.
- `clint_lsu_rdata` output 32: read data. 0 for writes.
- `clint_lsu_err` output 1: unmapped address; qualified by `clint_lsu_rsp_vld`.
- `clint_int_tmr` output 1: timer interrupt, drives `tmr_irq`.
- `clint_int_sft` output 1: software interrupt, drives `sft_irq`.

## Operation
- Register map:
  - 0x0000: MSIP. Bit 0 is R/W; bits 31:1 read 0.
  - 0x4000 / 0x4004: MTIMECMP lo / hi.
  - 0xBFF8 / 0xBFFC: MTIME lo / hi.
  - Any other offset sets `clint_lsu_err`=1 and returns `rdata` 0. Writes to unmapped offsets have no effect.
- FSM, two states:
  - IDLE: `clint_lsu_rdy`=1. On `lsu_clint_vld` the request is accepted, the write (if any) is performed that cycle, read data and err are captured into the response register, and the FSM goes to RESP.
  - RESP: `clint_lsu_rdy`=0 and `clint_lsu_rsp_vld`=1. The FSM returns to IDLE in the cycle `lsu_clint_rsp_rdy`=1. No new request is accepted in that same cycle.
- Response fields (`rdata`, `err`) stay stable for the whole time `rsp_vld` is high.
- `mtime`:
  - +1 per tick, 64-bit, wraps 0xFFFF_FFFF_FFFF_FFFF→0 silently.
  - Tick every clock without the macro; every `TICK_DIV` clocks with it.
  - A write to a 32-bit half replaces that half. A write and a tick in the same cycle: the written half takes the write value, the other half keeps its old value, and no carry propagates into it.
- Read of MTIME lo/hi returns the value before any same-cycle increment. There is no hi/lo snapshot; software uses the hi-lo-hi loop.
- `clint_int_tmr` is registered `mtime >= mtimecmp`, unsigned 64-bit compare, evaluated on the current register values.
- `clint_int_sft` is registered `msip`.

## Timing
- Reset values: `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `msip`=0, FSM=IDLE. Outputs after reset: `clint_lsu_rdy`=1, `rsp_vld`=0, `rdata`=0, `err`=0, `int_tmr`=0, `int_sft`=0. Prescaler count=0.
- Response latency: `rsp_vld` rises in the cycle after request acceptance. Throughput is at most one request every 2 cycles.
- A register write becomes visible at the next edge. The interrupt outputs reflect it one further cycle later: 2 edges from acceptance to `int_tmr`/`int_sft` change.
- `rst` asserted while in RESP drops `rsp_vld` next edge. The response is lost, and the pending write has already committed.
- `mtimecmp` written one half at a time can raise `int_tmr` spuriously between the two writes. This is documented software behaviour and not masked.

## Configuration
- `CLINT_PRESCALE_EN` defined: a 16-bit prescaler counts 0..`TICK_DIV`-1 and emits a tick on wrap. The prescaler resets to 0, and is also reset to 0 on any MTIME write.
- `CLINT_PRESCALE_EN` undefined: the tick is constant 1, `TICK_DIV` is ignored, and no prescaler logic exists.

## Structure
- Package `clint_pkg`:
  - Offset localparams `CLINT_MSIP`, `CLINT_MTIMECMP_LO/HI`, `CLINT_MTIME_LO/HI`.
  - FSM state enum (`CLINT_IDLE`, `CLINT_RESP`).
  - Reset constant `CLINT_MTIMECMP_RST`.
- Sub-module `clint_prescaler`: tick generator, instantiated only under `CLINT_PRESCALE_EN`.

## Test plan
- After reset, read 0x4000 and 0x4004 → both return 0xFFFF_FFFF. `int_tmr`=0, `int_sft`=0.
- Write 0x0000=1 → `int_sft`=1 two edges after acceptance. Write 0x0000=0 → `int_sft` returns to 0.
- Write MTIMECMP hi=0, lo=20, with mtime counting from 0 and no prescaler → `int_tmr` rises when mtime reaches 20 (+1 cycle). Writing lo=0xFFFF_FFFF afterwards deasserts it.
- Write MTIME lo=0xFFFF_FFFF, hi=0xFFFF_FFFF → the counter wraps to 0 after one tick. `int_tmr` with `mtimecmp`=5 goes 1→0 after the wrap.
- Read 0x1234 → `err`=1, `rdata`=0. Hold `rsp_rdy`=0 for 5 cycles → `clint_lsu_rdy` stays 0 and `rdata`/`err` stay stable. A new request issued in those cycles is not accepted.
- With `CLINT_PRESCALE_EN` and `TICK_DIV`=4 → mtime reads 25 after 100 clocks from reset.
